pipe_skid_stage: RTL

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_skid_stage.sv | 94 +++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pipe_pkg : state encodings shared by pipeline-stage blocks       |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package pipe_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BUSY  = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  function automatic logic [1:0] occ_of(input logic [1:0] st);
    case (st)
      BUSY:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pipe_skid_stage : two-entry skid buffer with registered ready    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             w_push, w_pop;

  assign w_push = in_valid & in_ready_q;
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = CLR_VAL;
      skid_d  = CLR_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_push) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (w_push && !w_pop) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (w_push && w_pop) begin
            main_d  = in_data;
          end else if (w_pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the stage
          if (w_pop) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Ready is a pure flop of the next state: no path from out_ready/in_valid.
  assign in_ready_d = (state_d != FULL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= CLR_VAL;
      skid_q     <= CLR_VAL;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);

endmodule
`default_nettype wire
